// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle control path: states, opcodes,
// immediate formats, ALU operations and writeback selects.
package mc_ctrl_pkg;

    localparam int unsigned STATE_W   = 3;
    localparam int unsigned OPC_W     = 7;
    localparam int unsigned IMM_SEL_W = 3;
    localparam int unsigned ALU_OP_W  = 4;
    localparam int unsigned WB_SEL_W  = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_FENCE  = 7'b0001111;
    localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [IMM_SEL_W-1:0] IMM_I = 3'd0;
    localparam logic [IMM_SEL_W-1:0] IMM_S = 3'd1;
    localparam logic [IMM_SEL_W-1:0] IMM_B = 3'd2;
    localparam logic [IMM_SEL_W-1:0] IMM_U = 3'd3;
    localparam logic [IMM_SEL_W-1:0] IMM_J = 3'd4;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd9;
    localparam logic [ALU_OP_W-1:0] ALU_LUI  = 4'd10;

    localparam logic [WB_SEL_W-1:0] WB_PC4 = 2'd0;
    localparam logic [WB_SEL_W-1:0] WB_ALU = 2'd1;
    localparam logic [WB_SEL_W-1:0] WB_LD  = 2'd2;

    // funct3/funct7 to ALU op; only register-register ops use funct7 for SUB
    function automatic logic [ALU_OP_W-1:0] alu_from_funct(input logic [2:0] f3,
                                                          input logic f7_5,
                                                          input logic is_rr);
        case (f3)
            3'b000:  return (is_rr && f7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return f7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational IR-field decode: datapath selects, instruction class and
// branch resolution.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       br_less,
    input  logic       br_equal,
    output logic [2:0] imm_sel,
    output logic [3:0] alu_op,
    output logic       opa_sel,
    output logic       opb_sel,
    output logic       br_un,
    output logic [1:0] wb_sel,
    output logic       is_branch,
    output logic       is_jump,
    output logic       is_load,
    output logic       is_store,
    output logic       no_wb,
    output logic       illegal,
    output logic       br_taken
);

    always_comb begin
        imm_sel   = IMM_I;
        alu_op    = ALU_ADD;
        opa_sel   = 1'b0;
        opb_sel   = 1'b0;
        br_un     = 1'b0;
        wb_sel    = WB_PC4;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        no_wb     = 1'b0;
        illegal   = 1'b0;
        case (op)
            OPC_OP: begin
                alu_op = alu_from_funct(funct3, funct7_5, 1'b1);
                wb_sel = WB_ALU;
            end
            OPC_OP_IMM: begin
                opb_sel = 1'b1;
                alu_op  = alu_from_funct(funct3, funct7_5, 1'b0);
                wb_sel  = WB_ALU;
            end
            OPC_LOAD: begin
                opb_sel = 1'b1;
                is_load = 1'b1;
                wb_sel  = WB_LD;
            end
            OPC_STORE: begin
                imm_sel  = IMM_S;
                opb_sel  = 1'b1;
                is_store = 1'b1;
            end
            OPC_BRANCH: begin
                imm_sel   = IMM_B;
                opa_sel   = 1'b1;
                opb_sel   = 1'b1;
                br_un     = funct3[2] & funct3[1];
                is_branch = 1'b1;
                illegal   = (funct3[2:1] == 2'b01);
            end
            OPC_JAL: begin
                imm_sel = IMM_J;
                opa_sel = 1'b1;
                opb_sel = 1'b1;
                is_jump = 1'b1;
            end
            OPC_JALR: begin
                opb_sel = 1'b1;
                is_jump = 1'b1;
            end
            OPC_LUI: begin
                imm_sel = IMM_U;
                opb_sel = 1'b1;
                alu_op  = ALU_LUI;
                wb_sel  = WB_ALU;
            end
            OPC_AUIPC: begin
                imm_sel = IMM_U;
                opa_sel = 1'b1;
                opb_sel = 1'b1;
                wb_sel  = WB_ALU;
            end
            OPC_FENCE, OPC_SYSTEM: no_wb = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

    // branch condition from BRC flags; reserved funct3 never takes
    always_comb begin
        case (funct3)
            3'b000:  br_taken = br_equal;
            3'b001:  br_taken = ~br_equal;
            3'b100:  br_taken = br_less;
            3'b101:  br_taken = ~br_less;
            3'b110:  br_taken = br_less;
            3'b111:  br_taken = ~br_less;
            default: br_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with req/ack memories
// and a single retire pulse (o_pc_wren) per instruction.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter bit RST_PC_EN = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [6:0] i_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    input  logic       i_br_less,
    input  logic       i_br_equal,
    input  logic       i_imem_ack,
    input  logic       i_dmem_ack,
    output logic       o_imem_req,
    output logic       o_ir_wren,
    output logic       o_pc_wren,
    output logic       o_pc_sel,
    output logic       o_rd_wren,
    output logic       o_opa_sel,
    output logic       o_opb_sel,
    output logic       o_br_un,
    output logic [2:0] o_imm_sel,
    output logic [3:0] o_alu_op,
    output logic [1:0] o_wb_sel,
    output logic       o_dmem_req,
    output logic       o_mem_wren,
    output logic       o_ldr_wren,
    output logic       o_insn_vld,
    output logic       o_illegal,
    output logic [2:0] o_state
);

    state_t     state, state_nxt;
    logic [2:0] imm_sel;
    logic [3:0] alu_op;
    logic [1:0] wb_sel;
    logic       opa_sel, opb_sel, br_un;
    logic       is_branch, is_jump, is_load, is_store, no_wb, illegal, br_taken;
    logic       retire;

    mc_decode u_decode (
        .op        (i_op),
        .funct3    (i_funct3),
        .funct7_5  (i_funct7_5),
        .br_less   (i_br_less),
        .br_equal  (i_br_equal),
        .imm_sel   (imm_sel),
        .alu_op    (alu_op),
        .opa_sel   (opa_sel),
        .opb_sel   (opb_sel),
        .br_un     (br_un),
        .wb_sel    (wb_sel),
        .is_branch (is_branch),
        .is_jump   (is_jump),
        .is_load   (is_load),
        .is_store  (is_store),
        .no_wb     (no_wb),
        .illegal   (illegal),
        .br_taken  (br_taken)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= S_FETCH;
        else          state <= state_nxt;
    end

    assign o_state = state;

    always_comb begin
        state_nxt  = state;
        retire     = 1'b0;
        o_imem_req = 1'b0;
        o_ir_wren  = 1'b0;
        o_pc_wren  = 1'b0;
        o_pc_sel   = 1'b0;
        o_rd_wren  = 1'b0;
        o_dmem_req = 1'b0;
        o_mem_wren = 1'b0;
        o_ldr_wren = 1'b0;
        o_imm_sel  = '0;
        o_alu_op   = '0;
        o_opa_sel  = 1'b0;
        o_opb_sel  = 1'b0;
        o_br_un    = 1'b0;
        o_wb_sel   = '0;

        // IR is only meaningful once latched
        if (state != S_FETCH) begin
            o_imm_sel = imm_sel;
            o_alu_op  = alu_op;
            o_opa_sel = opa_sel;
            o_opb_sel = opb_sel;
            o_br_un   = br_un;
            o_wb_sel  = wb_sel;
        end

        case (state)
            S_FETCH: begin
                o_imem_req = 1'b1;
                if (i_imem_ack) begin
                    o_ir_wren = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                if (illegal) begin
                    state_nxt = S_WB;
                end else if (is_branch) begin
                    o_pc_sel  = br_taken;
                    o_pc_wren = 1'b1;
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end else if (is_jump) begin
                    o_rd_wren = 1'b1;
                    o_pc_sel  = 1'b1;
                    o_pc_wren = 1'b1;
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end else if (is_load || is_store) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                o_dmem_req = 1'b1;
                o_mem_wren = is_store;
                if (i_dmem_ack) begin
                    if (is_store) begin
                        o_pc_wren = 1'b1;
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        o_ldr_wren = 1'b1;
                        state_nxt  = S_WB;
                    end
                end
            end
            S_WB: begin
                o_rd_wren = ~(no_wb | illegal);
                o_pc_wren = 1'b1;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase

        o_insn_vld = retire & ~illegal;
        o_illegal  = retire & illegal;

        // hold the datapath quiet while reset is asserted
        if (!i_rst_n) begin
            o_imem_req = 1'b0;
            o_ir_wren  = 1'b0;
            o_pc_wren  = RST_PC_EN;
            o_pc_sel   = 1'b0;
            o_rd_wren  = 1'b0;
            o_dmem_req = 1'b0;
            o_mem_wren = 1'b0;
            o_ldr_wren = 1'b0;
            o_insn_vld = 1'b0;
            o_illegal  = 1'b0;
            o_imm_sel  = '0;
            o_alu_op   = '0;
            o_opa_sel  = 1'b0;
            o_opb_sel  = 1'b0;
            o_br_un    = 1'b0;
            o_wb_sel   = '0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-instruction expected cycle traces built from
// instruction class, ack wait counts and hand-entered decode values.
module tb_mc_ctrl;

    localparam int C_WB  = 0;
    localparam int C_BR  = 1;
    localparam int C_JMP = 2;
    localparam int C_LD  = 3;
    localparam int C_ST  = 4;

    typedef struct packed {
        logic [2:0] state;
        logic       imem_req, ir_wren, pc_wren, pc_sel, rd_wren, opa, opb, br_un;
        logic [2:0] imm;
        logic [3:0] alu;
        logic [1:0] wb;
        logic       dmem_req, mem_wren, ldr_wren, vld, ill;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] insn;
        logic        less, equal;
        int          fw, dw, cls;
        logic [2:0]  imm;
        logic [3:0]  alu;
        logic        opa, opb, br_un;
        logic [1:0]  wb;
        logic        taken, rdw, ill;
        int          cyc, dmem;
    } vec_t;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [6:0] i_op;
    logic [2:0] i_funct3;
    logic       i_funct7_5, i_br_less, i_br_equal, i_imem_ack, i_dmem_ack;
    logic       o_imem_req, o_ir_wren, o_pc_wren, o_pc_sel, o_rd_wren;
    logic       o_opa_sel, o_opb_sel, o_br_un, o_dmem_req, o_mem_wren, o_ldr_wren;
    logic       o_insn_vld, o_illegal;
    logic [2:0] o_imm_sel, o_state;
    logic [3:0] o_alu_op;
    logic [1:0] o_wb_sel;

    int   total = 0;
    int   bad = 0;
    int   cyc_no = 0;
    int   ret_cnt = 0;
    int   dm_cnt = 0;
    exp_t tq[$];
    logic iaq[$];
    logic daq[$];
    vec_t vecs[$];

    always #5 i_clk = ~i_clk;

    mc_ctrl #(.RST_PC_EN(1'b1)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_op(i_op), .i_funct3(i_funct3),
        .i_funct7_5(i_funct7_5), .i_br_less(i_br_less), .i_br_equal(i_br_equal),
        .i_imem_ack(i_imem_ack), .i_dmem_ack(i_dmem_ack),
        .o_imem_req(o_imem_req), .o_ir_wren(o_ir_wren), .o_pc_wren(o_pc_wren),
        .o_pc_sel(o_pc_sel), .o_rd_wren(o_rd_wren), .o_opa_sel(o_opa_sel),
        .o_opb_sel(o_opb_sel), .o_br_un(o_br_un), .o_imm_sel(o_imm_sel),
        .o_alu_op(o_alu_op), .o_wb_sel(o_wb_sel), .o_dmem_req(o_dmem_req),
        .o_mem_wren(o_mem_wren), .o_ldr_wren(o_ldr_wren), .o_insn_vld(o_insn_vld),
        .o_illegal(o_illegal), .o_state(o_state)
    );

    function automatic vec_t mkv(string n, logic [31:0] insn, logic less, logic eq,
                                 int fw, int dw, int cls, logic [2:0] imm, logic [3:0] alu,
                                 logic opa, logic opb, logic brun, logic [1:0] wb,
                                 logic taken, logic rdw, logic ill, int cyc, int dmem);
        vec_t v;
        v.name = n; v.insn = insn; v.less = less; v.equal = eq; v.fw = fw; v.dw = dw;
        v.cls = cls; v.imm = imm; v.alu = alu; v.opa = opa; v.opb = opb; v.br_un = brun;
        v.wb = wb; v.taken = taken; v.rdw = rdw; v.ill = ill; v.cyc = cyc; v.dmem = dmem;
        return v;
    endfunction

    function automatic exp_t base(vec_t v, logic [2:0] st);
        exp_t e = '0;
        e.state = st;
        if (st != 3'd0) begin
            e.imm = v.imm; e.alu = v.alu; e.opa = v.opa; e.opb = v.opb;
            e.br_un = v.br_un; e.wb = v.wb;
        end
        return e;
    endfunction

    task automatic push(exp_t e, logic ia, logic da);
        tq.push_back(e); iaq.push_back(ia); daq.push_back(da);
    endtask

    // expected trace of one instruction; acks high except in wait cycles
    task automatic build(vec_t v);
        exp_t e;
        tq.delete(); iaq.delete(); daq.delete();
        for (int i = 0; i < v.fw; i++) begin
            e = base(v, 3'd0); e.imem_req = 1'b1; push(e, 1'b0, 1'b1);
        end
        e = base(v, 3'd0); e.imem_req = 1'b1; e.ir_wren = 1'b1; push(e, 1'b1, 1'b1);
        push(base(v, 3'd1), 1'b1, 1'b1);
        e = base(v, 3'd2);
        if (v.cls == C_BR || v.cls == C_JMP) begin
            e.pc_wren = 1'b1;
            e.pc_sel  = (v.cls == C_JMP) ? 1'b1 : v.taken;
            e.rd_wren = (v.cls == C_JMP);
            e.vld = 1'b1;
            push(e, 1'b1, 1'b1);
            return;
        end
        push(e, 1'b1, 1'b1);
        if (v.cls == C_LD || v.cls == C_ST) begin
            for (int i = 0; i <= v.dw; i++) begin
                e = base(v, 3'd3); e.dmem_req = 1'b1; e.mem_wren = (v.cls == C_ST);
                if (i == v.dw) begin
                    if (v.cls == C_ST) begin e.pc_wren = 1'b1; e.vld = 1'b1; end
                    else e.ldr_wren = 1'b1;
                end
                push(e, 1'b1, i == v.dw);
            end
            if (v.cls == C_ST) return;
        end
        e = base(v, 3'd4);
        e.rd_wren = v.rdw; e.pc_wren = 1'b1; e.vld = ~v.ill; e.ill = v.ill;
        push(e, 1'b1, 1'b1);
    endtask

    task automatic check(string n, exp_t e);
        exp_t a;
        a = {o_state, o_imem_req, o_ir_wren, o_pc_wren, o_pc_sel, o_rd_wren, o_opa_sel,
             o_opb_sel, o_br_un, o_imm_sel, o_alu_op, o_wb_sel, o_dmem_req, o_mem_wren,
             o_ldr_wren, o_insn_vld, o_illegal};
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s cyc=%0d outputs act=%h exp=%h", n, cyc_no, a, e);
        end
        if (o_pc_wren === 1'b1) ret_cnt++;
        if (o_dmem_req === 1'b1) dm_cnt++;
    endtask

    task automatic check_int(string n, int act, int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", n, act, expv);
        end
    endtask

    // one cycle: drive at posedge+1, compare at negedge, return at next posedge+1
    task automatic step(string n, exp_t e, logic ia, logic da);
        i_imem_ack = ia; i_dmem_ack = da;
        @(negedge i_clk);
        check(n, e);
        @(posedge i_clk); #1;
        cyc_no++;
    endtask

    task automatic run_vec(vec_t v, int abort_at);
        int r0, d0;
        build(v);
        r0 = ret_cnt; d0 = dm_cnt;
        i_op = v.insn[6:0]; i_funct3 = v.insn[14:12]; i_funct7_5 = v.insn[30];
        i_br_less = v.less; i_br_equal = v.equal;
        for (int i = 0; i < tq.size(); i++) begin
            if (abort_at >= 0 && i == abort_at) return;
            step(v.name, tq[i], iaq[i], daq[i]);
        end
        check_int({v.name, "_latency"}, tq.size(), v.cyc);
        check_int({v.name, "_retires"}, ret_cnt - r0, 1);
        check_int({v.name, "_dmem_cycles"}, dm_cnt - d0, v.dmem);
    endtask

    initial begin
        exp_t r;
        vecs.push_back(mkv("addi",  32'h00500093, 0, 0, 0, 0, C_WB,  0, 0,  0, 1, 0, 1, 0, 1, 0, 4, 0));
        vecs.push_back(mkv("beq_t", 32'h00208463, 0, 1, 0, 0, C_BR,  2, 0,  1, 1, 0, 0, 1, 0, 0, 3, 0));
        vecs.push_back(mkv("beq_n", 32'h00208463, 0, 0, 0, 0, C_BR,  2, 0,  1, 1, 0, 0, 0, 0, 0, 3, 0));
        vecs.push_back(mkv("lw",    32'h0000A183, 0, 0, 0, 3, C_LD,  0, 0,  0, 1, 0, 2, 0, 1, 0, 8, 4));
        vecs.push_back(mkv("sw",    32'h0020A023, 0, 0, 0, 0, C_ST,  1, 0,  0, 1, 0, 0, 0, 0, 0, 4, 1));
        vecs.push_back(mkv("ill7f", 32'h0000007F, 1, 1, 0, 0, C_WB,  0, 0,  0, 0, 0, 0, 0, 0, 1, 4, 0));
        vecs.push_back(mkv("sub",   32'h402081B3, 0, 0, 0, 0, C_WB,  0, 1,  0, 0, 0, 1, 0, 1, 0, 4, 0));
        vecs.push_back(mkv("bltu",  32'h0020E463, 1, 0, 2, 0, C_BR,  2, 0,  1, 1, 1, 0, 1, 0, 0, 5, 0));
        vecs.push_back(mkv("jal",   32'h010000EF, 0, 0, 0, 0, C_JMP, 4, 0,  1, 1, 0, 0, 0, 0, 0, 3, 0));
        vecs.push_back(mkv("jalr",  32'h00008067, 0, 0, 0, 0, C_JMP, 0, 0,  0, 1, 0, 0, 0, 0, 0, 3, 0));
        vecs.push_back(mkv("lui",   32'h123452B7, 0, 0, 0, 0, C_WB,  3, 10, 0, 1, 0, 1, 0, 1, 0, 4, 0));
        vecs.push_back(mkv("auipc", 32'h00000297, 0, 0, 0, 0, C_WB,  3, 0,  1, 1, 0, 1, 0, 1, 0, 4, 0));
        vecs.push_back(mkv("srai",  32'h4030D093, 0, 0, 0, 0, C_WB,  0, 7,  0, 1, 0, 1, 0, 1, 0, 4, 0));
        vecs.push_back(mkv("ecall", 32'h00000073, 0, 0, 0, 0, C_WB,  0, 0,  0, 0, 0, 0, 0, 0, 0, 4, 0));
        vecs.push_back(mkv("b_ill", 32'h0020A463, 1, 1, 0, 0, C_WB,  2, 0,  1, 1, 0, 0, 0, 0, 1, 4, 0));
        vecs.push_back(mkv("bge",   32'h0020D463, 0, 0, 0, 0, C_BR,  2, 0,  1, 1, 0, 0, 1, 0, 0, 3, 0));
        vecs.push_back(mkv("sw_w",  32'h0020A023, 0, 0, 1, 2, C_ST,  1, 0,  0, 1, 0, 0, 0, 0, 0, 7, 3));

        i_rst_n = 1'b0; i_op = '0; i_funct3 = '0; i_funct7_5 = 1'b0;
        i_br_less = 1'b0; i_br_equal = 1'b0; i_imem_ack = 1'b1; i_dmem_ack = 1'b1;
        @(posedge i_clk); #1;
        r = '0; r.pc_wren = 1'b1;
        step("reset", r, 1'b1, 1'b1);
        i_rst_n = 1'b1;

        foreach (vecs[k]) run_vec(vecs[k], -1);

        // reset in the third S_MEM cycle of a slow store
        run_vec(mkv("sw_rst", 32'h0020A023, 0, 0, 0, 5, C_ST, 1, 0, 0, 1, 0, 0, 0, 0, 0, 9, 6), 5);
        i_rst_n = 1'b0;
        r = '0; r.state = 3'd3; r.pc_wren = 1'b1;
        step("rst_in_mem", r, 1'b0, 1'b1);
        i_rst_n = 1'b1;
        r = '0; r.imem_req = 1'b1;
        step("after_rst", r, 1'b0, 1'b1);
        step("late_ack", r, 1'b0, 1'b1);

        run_vec(vecs[0], -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multicycle sequencer for the RV32I datapath (PC, instruction memory, regfile, immgen, BRC, ALU, LSU, writeback mux).
- Replaces single-cycle control so that instruction and data memories can use a variable-latency req/ack handshake.
- Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath enables, mux selects and memory requests.
- Produces a one-cycle retire pulse per instruction.

Parameters:
- RST_PC_EN, 1, when 1 o_pc_wren is asserted during reset so the datapath PC register loads its reset vector; when 0 it is held low.

Ports:
- i_clk  in  1  global clock, rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_op  in  7  IR[6:0]
- i_funct3  in  3  IR[14:12]
- i_funct7_5  in  1  IR[30]
- i_br_less  in  1  BRC less-than result
- i_br_equal  in  1  BRC equal result
- i_imem_ack  in  1  instruction word valid this cycle
- i_dmem_ack  in  1  data access complete this cycle
- o_imem_req  out  1  instruction fetch request
- o_ir_wren  out  1  latch IR
- o_pc_wren  out  1  update PC (retire strobe)
- o_pc_sel  out  1  0 = pc+4, 1 = ALU result
- o_rd_wren  out  1  regfile write
- o_opa_sel  out  1  0 = rs1, 1 = pc
- o_opb_sel  out  1  0 = rs2, 1 = imm
- o_br_un  out  1  unsigned compare
- o_imm_sel  out  3  immediate format
- o_alu_op  out  4  ALU operation
- o_wb_sel  out  2  0 = pc+4, 1 = ALU, 2 = load data
- o_dmem_req  out  1  data memory request
- o_mem_wren  out  1  store qualifier, valid with o_dmem_req
- o_ldr_wren  out  1  latch load data register
- o_insn_vld  out  1  legal instruction retired this cycle
- o_illegal  out  1  illegal opcode retired this cycle
- o_state  out  3  current state, debug

Behaviour:
- Reset (i_rst_n low at a rising edge):
  - state goes to S_FETCH.
  - All 1-bit outputs are 0, except o_pc_wren = RST_PC_EN; all multi-bit outputs are 0.
  - Reset mid-request drops the request; a late ack is ignored.
- States: S_FETCH=0, S_DECODE=1, S_EXEC=2, S_MEM=3, S_WB=4. Codes 5-7 go to S_FETCH.
- Decode outputs (o_imm_sel, o_alu_op, o_opa_sel, o_opb_sel, o_br_un, o_wb_sel) are combinational from the IR inputs. They are driven from S_DECODE onward and forced to 0 in S_FETCH.
- S_FETCH:
  - o_imem_req = 1.
  - On i_imem_ack: o_ir_wren = 1 and go to S_DECODE. Otherwise stay.
- S_DECODE:
  - Regfile and BRC settle. Always go to S_EXEC.
  - An unknown opcode is flagged illegal here.
- S_EXEC:
  - BRANCH: taken = f(funct3, i_br_less, i_br_equal), with o_br_un = 1 for BLTU/BGEU. o_pc_sel = taken, o_pc_wren = 1, retire, go to S_FETCH. funct3 010/011 is illegal.
  - JAL/JALR: o_rd_wren = 1 with wb_sel = 0 and o_pc_sel = 1 on the same edge (rd gets the old pc+4). Retire, go to S_FETCH.
  - LOAD/STORE: go to S_MEM.
  - All others: go to S_WB.
- S_MEM:
  - o_dmem_req = 1; o_mem_wren = 1 for STORE. Both are held stable until i_dmem_ack.
  - On ack, STORE: o_pc_wren = 1 with pc_sel = 0, retire, go to S_FETCH.
  - On ack, LOAD: o_ldr_wren = 1, go to S_WB.
- S_WB:
  - o_rd_wren = 1, except FENCE/ECALL/illegal.
  - o_pc_wren = 1, pc_sel = 0, retire, go to S_FETCH.
- Retire:
  - Exactly one cycle per instruction with o_pc_wren = 1.
  - o_insn_vld = ~illegal; o_illegal = illegal; never both.
  - Illegal opcodes take the S_WB path and advance pc+4.
- Latency with zero-wait ack (fetch to retire inclusive):
  - branch / jal / jalr: 3 cycles
  - R / I / LUI / AUIPC / store: 4 cycles
  - load: 5 cycles
- Ack handling:
  - Each wait state adds one cycle.
  - Ack without a matching req is ignored.
  - i_imem_ack in S_MEM has no effect.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum
  - opcode constants (LOAD, STORE, BRANCH, JAL, JALR, OP, OP_IMM, LUI, AUIPC, FENCE, SYSTEM)
  - imm_sel and alu_op encodings, shared with immgen/alu
  - wb_sel codes
- One sub-module, mc_decode: purely combinational IR-field decode. The FSM stays in mc_ctrl.

Test Plan:
- ADDI x1,x0,5 (0x00500093), acks tied high -> retire on cycle 4: o_insn_vld = 1, o_rd_wren = 1 in S_WB, o_alu_op = ADD, o_opb_sel = 1.
- BEQ with i_br_equal = 1 -> o_pc_sel = 1, o_pc_wren = 1 in S_EXEC on cycle 3. Same with i_br_equal = 0 -> o_pc_sel = 0.
- LW with i_dmem_ack delayed 3 cycles -> o_dmem_req high for exactly 4 S_MEM cycles, o_mem_wren = 0; o_ldr_wren on the ack cycle; retire on cycle 8.
- SW, ack immediate -> o_mem_wren = 1 with o_dmem_req; retire in S_MEM on cycle 4 with o_rd_wren = 0 throughout.
- Opcode 0x7F -> o_illegal = 1, o_insn_vld = 0, o_rd_wren = 0, pc+4 on cycle 4.
- i_rst_n low during S_MEM of a store -> next cycle: o_state = 0, o_dmem_req = 0, o_mem_wren = 0. An ack then arriving causes no retire.
